// File: rtl/hdc_query_engine.sv
// Nearest-class search over stored class hypervectors by chunk-serial Hamming distance.
// Optional build macro HDC_QUERY_ACCURACY_EN adds query_label / correct_cnt accuracy tracking.
module hdc_query_engine #(
   parameter int DIM         = 1024,
   parameter int CHUNK       = 64,
   parameter int NUM_CLASSES = 10,
   parameter int SAMPLE_W    = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            class_wr_en,
   input  logic [$clog2(NUM_CLASSES)-1:0]  class_wr_addr,
   input  logic [$clog2(DIM/CHUNK)-1:0]    class_wr_chunk,
   input  logic [CHUNK-1:0]                class_wr_data,
   input  logic                            start_querying,
   input  logic [DIM-1:0]                  query_hv,
   input  logic [SAMPLE_W-1:0]             num_test_samples,
   output logic                            busy,
   output logic                            pred_valid,
   output logic [$clog2(NUM_CLASSES)-1:0]  pred_class,
   output logic [$clog2(DIM+1)-1:0]        pred_dist,
   output logic [SAMPLE_W-1:0]             sample_cnt,
   output logic                            testing_dataset_finished
`ifdef HDC_QUERY_ACCURACY_EN
   ,
   input  logic [$clog2(NUM_CLASSES)-1:0]  query_label,
   output logic [SAMPLE_W-1:0]             correct_cnt
`endif
);

   localparam int NCHUNK = DIM / CHUNK;
   localparam int CW     = $clog2(NUM_CLASSES);
   localparam int KW     = $clog2(NCHUNK);
   localparam int PW     = $clog2(CHUNK + 1);
   localparam int DW     = $clog2(DIM + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPUTE = 2'd1,
      S_DECIDE  = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   function automatic logic [PW-1:0] popcount(input logic [CHUNK-1:0] v);
      logic [PW-1:0] c;
      c = '0;
      for (int i = 0; i < CHUNK; i++) begin
         c = c + PW'(v[i]);
      end
      return c;
   endfunction

   state_t               state_r, next_state_s;
   logic [CHUNK-1:0]     class_mem_r [NUM_CLASSES][NCHUNK];

   logic [CW-1:0]        cls_idx_r;
   logic [KW-1:0]        chunk_idx_r;
   logic [DW-1:0]        acc_r;
   logic [DW-1:0]        best_dist_r, best_dist_nx_s;
   logic [CW-1:0]        best_idx_r, best_idx_nx_s;

   logic                 busy_r, pred_valid_r, finished_r;
   logic [CW-1:0]        pred_class_r;
   logic [DW-1:0]        pred_dist_r;
   logic [SAMPLE_W-1:0]  sample_cnt_r;

   logic                 wr_ok_s, done_s, last_chunk_s, last_class_s, upd_s;
   logic [CHUNK-1:0]     q_chunk_s, c_chunk_s;
   logic [PW-1:0]        chunk_pc_s;
   logic [DW-1:0]        dist_s;

   assign busy                     = busy_r;
   assign pred_valid               = pred_valid_r;
   assign pred_class               = pred_class_r;
   assign pred_dist                = pred_dist_r;
   assign sample_cnt               = sample_cnt_r;
   assign testing_dataset_finished = finished_r;

   assign wr_ok_s = class_wr_en && (state_r == S_IDLE)
                    && ({1'b0, class_wr_addr}  < (CW+1)'(NUM_CLASSES))
                    && ({1'b0, class_wr_chunk} < (KW+1)'(NCHUNK));

   // Class memory: writable only while idle, never reset
   always_ff @(posedge clk) begin
      if (wr_ok_s) begin
         class_mem_r[class_wr_addr][class_wr_chunk] <= class_wr_data;
      end
   end

   assign done_s       = (sample_cnt_r >= num_test_samples);
   assign last_chunk_s = (chunk_idx_r == KW'(NCHUNK - 1));
   assign last_class_s = (cls_idx_r == CW'(NUM_CLASSES - 1));
   assign q_chunk_s    = query_hv[chunk_idx_r * CHUNK +: CHUNK];
   assign c_chunk_s    = class_mem_r[cls_idx_r][chunk_idx_r];
   assign chunk_pc_s   = popcount(q_chunk_s ^ c_chunk_s);
   assign dist_s       = acc_r + DW'(chunk_pc_s);

   // Next-state selection; exhaustion of the test set wins over a start pulse
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (done_s) begin
               next_state_s = S_DONE;
            end else if (start_querying) begin
               next_state_s = S_COMPUTE;
            end else begin
               next_state_s = S_IDLE;
            end
         end
         S_COMPUTE: begin
            if (last_chunk_s && last_class_s) begin
               next_state_s = S_DECIDE;
            end else begin
               next_state_s = S_COMPUTE;
            end
         end
         S_DECIDE: next_state_s = S_IDLE;
         S_DONE:   next_state_s = S_DONE;
         default:  next_state_s = S_IDLE;
      endcase
   end

   // Running winner; strict compare keeps the lower class index on ties
   always_comb begin
      upd_s          = 1'b0;
      best_dist_nx_s = best_dist_r;
      best_idx_nx_s  = best_idx_r;
      if ((state_r == S_COMPUTE) && last_chunk_s && (dist_s < best_dist_r)) begin
         upd_s          = 1'b1;
         best_dist_nx_s = dist_s;
         best_idx_nx_s  = cls_idx_r;
      end else begin
         upd_s = 1'b0;
      end
   end

   // State register and chunk-serial datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= S_IDLE;
         cls_idx_r   <= '0;
         chunk_idx_r <= '0;
         acc_r       <= '0;
         best_dist_r <= '0;
         best_idx_r  <= '0;
      end else begin
         state_r <= next_state_s;
         case (state_r)
            S_IDLE: begin
               if (!done_s && start_querying) begin
                  cls_idx_r   <= '0;
                  chunk_idx_r <= '0;
                  acc_r       <= '0;
                  best_dist_r <= '1;
                  best_idx_r  <= '0;
               end
            end
            S_COMPUTE: begin
               best_dist_r <= best_dist_nx_s;
               best_idx_r  <= best_idx_nx_s;
               if (last_chunk_s) begin
                  chunk_idx_r <= '0;
                  acc_r       <= '0;
                  cls_idx_r   <= last_class_s ? '0 : cls_idx_r + 1'b1;
               end else begin
                  chunk_idx_r <= chunk_idx_r + 1'b1;
                  acc_r       <= dist_s;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Registered outputs; results land as the block enters S_DECIDE so they align with pred_valid
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r       <= 1'b0;
         pred_valid_r <= 1'b0;
         finished_r   <= 1'b0;
         pred_class_r <= '0;
         pred_dist_r  <= '0;
         sample_cnt_r <= '0;
      end else begin
         busy_r       <= (next_state_s == S_COMPUTE) || (next_state_s == S_DECIDE);
         pred_valid_r <= (next_state_s == S_DECIDE);
         finished_r   <= (next_state_s == S_DONE);
         if (next_state_s == S_DECIDE) begin
            pred_class_r <= best_idx_nx_s;
            pred_dist_r  <= best_dist_nx_s;
            if (sample_cnt_r != '1) begin
               sample_cnt_r <= sample_cnt_r + 1'b1;
            end
         end
      end
   end

`ifdef HDC_QUERY_ACCURACY_EN
   logic [CW-1:0]       label_r;
   logic [SAMPLE_W-1:0] correct_cnt_r;

   assign correct_cnt = correct_cnt_r;

   // Label captured with the query; hit counted alongside the prediction
   always_ff @(posedge clk) begin
      if (rst) begin
         label_r       <= '0;
         correct_cnt_r <= '0;
      end else begin
         if ((state_r == S_IDLE) && !done_s && start_querying) begin
            label_r <= query_label;
         end
         if ((next_state_s == S_DECIDE) && (best_idx_nx_s == label_r)
             && (correct_cnt_r != '1)) begin
            correct_cnt_r <= correct_cnt_r + 1'b1;
         end
      end
   end
`else
   // Accuracy tracking not built in this configuration
`endif

endmodule

// File: doc/hdc_query_engine.md
# hdc_query_engine

Inference-side similarity stage of the one-shot HDC pipeline. Stores the class hypervectors produced during training. On each `start_querying` pulse it compares the current encoded query hypervector against every stored class by Hamming distance, chunk-serially, and reports the nearest class. It counts classified samples and raises `testing_dataset_finished` back to the one-shot controller once the programmed test set has been consumed.

## Interface
- `DIM`, 1024: hypervector width in bits; must be a multiple of `CHUNK`.
- `CHUNK`, 64: bits compared per cycle; NCHUNK = DIM/CHUNK.
- `NUM_CLASSES`, 10: number of stored class hypervectors; CW = $clog2(NUM_CLASSES).
- `SAMPLE_W`, 16: width of the sample counter.

Ports:
- `clk` in 1: clock; single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `class_wr_en` in 1: write one chunk of class memory.
- `class_wr_addr` in CW: class index.
- `class_wr_chunk` in $clog2(NCHUNK): chunk index within the class.
- `class_wr_data` in CHUNK: chunk data.
- `start_querying` in 1: single-cycle pulse; `query_hv` is valid.
- `query_hv` in DIM: encoded query, held stable by the encoder until `pred_valid`.
- `num_test_samples` in SAMPLE_W: test-set size; static during testing.
- `busy` out 1: comparison in progress.
- `pred_valid` out 1: one-cycle pulse; prediction outputs updated.
- `pred_class` out CW: index of the nearest class.
- `pred_dist` out $clog2(DIM+1): Hamming distance of the winner.
- `sample_cnt` out SAMPLE_W: number of predictions made since reset.
- `testing_dataset_finished` out 1: level; test set complete.

## Operation
- Class memory: NUM_CLASSES × DIM register array, not reset.
  - A write lands on the clock edge when `class_wr_en` is high and state is S_IDLE.
  - Writes in any other state are dropped.
  - Out-of-range `class_wr_addr` is dropped.
- States: S_IDLE, S_COMPUTE, S_DECIDE, S_DONE.
- S_IDLE:
  - If `sample_cnt >= num_test_samples`, go to S_DONE. This takes priority over start.
  - Otherwise, on `start_querying`, go to S_COMPUTE and clear cls_idx, chunk_idx, acc, best_dist (set to all-ones) and best_idx.
- S_COMPUTE, one chunk per cycle:
  - acc += popcount(query chunk XOR class chunk).
  - On the last chunk of a class: if (acc + this chunk's popcount) < best_dist, update best_dist and best_idx. The comparison is strict, so ties keep the lower class index.
  - Then clear acc and advance cls_idx.
  - After the last chunk of the last class, go to S_DECIDE.
- S_DECIDE:
  - Register `pred_class` = best_idx and `pred_dist` = best_dist.
  - Pulse `pred_valid`, increment `sample_cnt` (saturating), return to S_IDLE.
- S_DONE: terminal until `rst`. `start_querying` and class writes are ignored.
- `busy` = (state == S_COMPUTE) or (state == S_DECIDE).
- `testing_dataset_finished` = (state == S_DONE).
- `start_querying` while busy is ignored. It is not queued.
- Widths:
  - Chunk popcount: $clog2(CHUNK+1) bits.
  - acc and distances: $clog2(DIM+1) bits, zero-extended; no overflow is possible.

## Timing
- Reset values:
  - state S_IDLE; `busy` 0, `pred_valid` 0, `pred_class` 0, `pred_dist` 0, `sample_cnt` 0, `testing_dataset_finished` 0.
  - Internal counters and the accumulator are 0.
  - Class memory is unaffected.
- Start accepted at edge T0, so S_COMPUTE begins in the cycle after T0.
  - NUM_CLASSES × NCHUNK compute cycles follow, then one S_DECIDE cycle.
  - `pred_valid` is high in cycle T0 + NUM_CLASSES·NCHUNK + 1.
- `pred_class` and `pred_dist` change only on `pred_valid` and hold until the next one.
- After the final sample, `testing_dataset_finished` rises 2 cycles after the `pred_valid` cycle: one cycle back in S_IDLE, then S_DONE.
- `num_test_samples` = 0 drives the block to S_DONE in the second cycle after reset deassertion.
- Back-to-back: the earliest accepted restart is the cycle after `pred_valid`, when the block is back in S_IDLE.
- `rst` asserted mid-compute aborts the query: no `pred_valid` is produced and all outputs return to their reset values on the next edge.

## Configuration
- `HDC_QUERY_ACCURACY_EN`
  - Defined:
    - Adds input `query_label` (CW) and output `correct_cnt` (SAMPLE_W, reset 0).
    - In S_DECIDE, `correct_cnt` increments (saturating) when best_idx == `query_label`.
    - `query_label` is sampled with `query_hv` at start.
  - Undefined: neither port exists and no comparison logic is built.

## Test plan
Common parameters: DIM=256, CHUNK=64, NUM_CLASSES=4, so NCHUNK=4 and 16 compute cycles.

1. Load class0=0s, class1=1s, class2=0x55…, class3=0xAA…. Query all zeros with start at T0 → `pred_valid` at T0+17, `pred_class`=0, `pred_dist`=0, `sample_cnt`=1.
2. Same classes, query = 0xAA… → `pred_class`=3, `pred_dist`=0. Then query = 0x0F… (distance 128 to every class) → tie resolves to `pred_class`=0, `pred_dist`=128.
3. Extra `start_querying` pulses at T0+5 and T0+16, plus a class write at T0+3 → exactly one `pred_valid`; class memory unchanged.
4. `num_test_samples`=3, three queries back-to-back → `testing_dataset_finished` rises 2 cycles after the third `pred_valid`. A fourth start produces no `pred_valid`.
5. `rst` at T0+8 mid-compute → no `pred_valid`; all outputs 0 next cycle. A subsequent query completes with class data intact.
6. With `HDC_QUERY_ACCURACY_EN`, run scenario 1's query with labels 0, then 2 → `correct_cnt` is 1 after both predictions.
